fifo4_push_arb_ctrl: RTL and testbench

Control block for the 4-entry register FIFO, shared by two producers (A and B). It arbitrates push requests round-robin and tracks the head/tail pointers, occupancy and full/empty state. It also drives the per-entry write enables and the write-data select for the FIFO register array. The FIFO data registers and the read mux sit outside this block, steered by `wr_en`, `wr_sel` and `curr_head`.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo4_push_arb_ctrl_if.sv | 31 +++
 rtl/fifo4_push_arb_ctrl_rr_arb2.sv | 32 +++
 rtl/fifo4_push_arb_ctrl.sv | 109 ++++++++++
 tb/tb_fifo4_push_arb_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and FSM encoding for the 4-entry FIFO push/pop controller.
package fifo_pkg;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_PARTIAL = 2'b01,
        ST_FULL    = 2'b10
    } state_t;

    localparam logic WR_SEL_A = 1'b0;
    localparam logic WR_SEL_B = 1'b1;

endpackage

// File: rtl/fifo4_push_arb_ctrl_if.sv
// Handshake and status bundle between producers/consumer and the FIFO controller.
interface fifo4_push_arb_ctrl_if;
    import fifo_pkg::*;

    logic             req_a;
    logic             req_b;
    logic             pop_fifo;
    logic             gnt_a;
    logic             gnt_b;
    logic             pop_ok;
    logic [DEPTH-1:0] wr_en;
    logic             wr_sel;
    logic [PTR_W-1:0] curr_head;
    logic [PTR_W-1:0] curr_tail;
    logic [CNT_W-1:0] count;
    logic             fifo_empty;
    logic             fifo_full;

    modport master (
        output req_a, req_b, pop_fifo,
        input  gnt_a, gnt_b, pop_ok, wr_en, wr_sel,
        input  curr_head, curr_tail, count, fifo_empty, fifo_full
    );

    modport slave (
        input  req_a, req_b, pop_fifo,
        output gnt_a, gnt_b, pop_ok, wr_en, wr_sel,
        output curr_head, curr_tail, count, fifo_empty, fifo_full
    );

endinterface

// File: rtl/fifo4_push_arb_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; req[0]/gnt[0] is producer A, req[1]/gnt[1] is B.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic r_last_b;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = r_last_b ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Priority only moves on a real grant, so a blocked push keeps its turn.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_last_b <= 1'b0;
        else if (|gnt)
            r_last_b <= gnt[1];
    end

endmodule

// File: rtl/fifo4_push_arb_ctrl.sv
// Push arbitration, head/tail pointers and occupancy FSM for a 4-entry register FIFO.
//   state      | meaning
//   ST_EMPTY   | no entries; pops are ignored
//   ST_PARTIAL | 1..3 entries; push and pop both allowed
//   ST_FULL    | 4 entries; pushes blocked, pop allowed
module fifo4_push_arb_ctrl #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input logic                  clk,
    input logic                  rst,
    fifo4_push_arb_ctrl_if.slave bus
);

    localparam int CW = fifo_pkg::CNT_W;

    fifo_pkg::state_t r_state;
    fifo_pkg::state_t w_state_nxt;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic [1:0]       w_gnt;
    logic             w_full;
    logic             w_empty;
    logic             w_gnt_a;
    logic             w_gnt_b;
    logic             w_push;
    logic             w_pop;
    logic [DEPTH-1:0] w_wr_en;

    assign w_full  = (r_state == fifo_pkg::ST_FULL);
    assign w_empty = (r_state == fifo_pkg::ST_EMPTY);

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({bus.req_b, bus.req_a}),
        .en  (~w_full),
        .gnt (w_gnt)
    );

    // Grants are masked while reset is held so no write strobe escapes.
    assign w_gnt_a = w_gnt[0] & rst;
    assign w_gnt_b = w_gnt[1] & rst;
    assign w_push  = w_gnt_a | w_gnt_b;
    assign w_pop   = bus.pop_fifo & ~w_empty & rst;
    assign w_wr_en = w_push ? ({{(DEPTH-1){1'b0}}, 1'b1} << r_tail) : '0;

    assign bus.gnt_a      = w_gnt_a;
    assign bus.gnt_b      = w_gnt_b;
    assign bus.pop_ok     = w_pop;
    assign bus.wr_en      = w_wr_en;
    assign bus.wr_sel     = w_gnt_b ? fifo_pkg::WR_SEL_B : fifo_pkg::WR_SEL_A;
    assign bus.curr_head  = r_head;
    assign bus.curr_tail  = r_tail;
    assign bus.count      = r_count;
    assign bus.fifo_empty = w_empty;
    assign bus.fifo_full  = w_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_tail <= r_tail + PTR_W'(1);
            if (w_pop)
                r_head <= r_head + PTR_W'(1);
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= fifo_pkg::ST_EMPTY;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_count_nxt = r_count;
        w_state_nxt = r_state;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
        case (r_state)
            fifo_pkg::ST_EMPTY: begin
                if (w_push)
                    w_state_nxt = fifo_pkg::ST_PARTIAL;
            end
            fifo_pkg::ST_PARTIAL: begin
                if (w_push && !w_pop && r_count == CW'(DEPTH - 1))
                    w_state_nxt = fifo_pkg::ST_FULL;
                else if (w_pop && !w_push && r_count == CW'(1))
                    w_state_nxt = fifo_pkg::ST_EMPTY;
            end
            fifo_pkg::ST_FULL: begin
                if (w_pop)
                    w_state_nxt = fifo_pkg::ST_PARTIAL;
            end
            default: w_state_nxt = fifo_pkg::ST_EMPTY;
        endcase
    end

endmodule

// File: tb/tb_fifo4_push_arb_ctrl.sv
// Bench for fifo4_push_arb_ctrl: queue-based reference model checked every cycle plus directed literals.
module tb_fifo4_push_arb_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fifo4_push_arb_ctrl_if bus();

    fifo4_push_arb_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: queue of producer tags (1 = A, 2 = B), total push/pop counts, last winner.
    int m_q[$];
    int m_pushes = 0;
    int m_pops   = 0;
    bit m_last_b = 1'b0;
    int sz;
    int win;
    bit po;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            m_q.delete();
            m_pushes = 0;
            m_pops   = 0;
            m_last_b = 1'b0;
            chk("rst_gnt_a", int'(bus.gnt_a), 0);
            chk("rst_gnt_b", int'(bus.gnt_b), 0);
            chk("rst_pop_ok", int'(bus.pop_ok), 0);
            chk("rst_wr_en", int'(bus.wr_en), 0);
            chk("rst_wr_sel", int'(bus.wr_sel), 0);
            chk("rst_head", int'(bus.curr_head), 0);
            chk("rst_tail", int'(bus.curr_tail), 0);
            chk("rst_count", int'(bus.count), 0);
            chk("rst_empty", int'(bus.fifo_empty), 1);
            chk("rst_full", int'(bus.fifo_full), 0);
        end else begin
            sz  = m_q.size();
            win = 0;
            if (sz < 4) begin
                if (bus.req_a && bus.req_b) win = m_last_b ? 1 : 2;
                else if (bus.req_a)         win = 1;
                else if (bus.req_b)         win = 2;
            end
            po = bus.pop_fifo && (sz > 0);
            chk("m_gnt_a", int'(bus.gnt_a), int'(win == 1));
            chk("m_gnt_b", int'(bus.gnt_b), int'(win == 2));
            chk("m_pop_ok", int'(bus.pop_ok), int'(po));
            chk("m_wr_en", int'(bus.wr_en), (win != 0) ? (1 << (m_pushes % 4)) : 0);
            chk("m_wr_sel", int'(bus.wr_sel), int'(win == 2));
            chk("m_head", int'(bus.curr_head), m_pops % 4);
            chk("m_tail", int'(bus.curr_tail), m_pushes % 4);
            chk("m_count", int'(bus.count), sz);
            chk("m_empty", int'(bus.fifo_empty), int'(sz == 0));
            chk("m_full", int'(bus.fifo_full), int'(sz == 4));
            if (po) begin
                void'(m_q.pop_front());
                m_pops++;
            end
            if (win != 0) begin
                m_q.push_back(win);
                m_pushes++;
                m_last_b = (win == 2);
            end
        end
    end

    // Drive new inputs 1 time unit after the edge, return 1 unit later for literal checks.
    task automatic drive(input bit a, input bit b, input bit p);
        @(posedge clk);
        #1;
        bus.req_a    = a;
        bus.req_b    = b;
        bus.pop_fifo = p;
        #1;
    endtask

    task automatic pulse_reset();
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        bus.req_a    = 1'b0;
        bus.req_b    = 1'b0;
        bus.pop_fifo = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("lit_reset_empty", int'(bus.fifo_empty), 1);
        chk("lit_reset_count", int'(bus.count), 0);

        // A, A, B, B single requesters fill the FIFO
        drive(1, 0, 0);
        chk("lit_aabb_wr_en0", int'(bus.wr_en), 1);
        chk("lit_aabb_sel0", int'(bus.wr_sel), 0);
        drive(1, 0, 0);
        chk("lit_aabb_wr_en1", int'(bus.wr_en), 2);
        chk("lit_aabb_sel1", int'(bus.wr_sel), 0);
        drive(0, 1, 0);
        chk("lit_aabb_wr_en2", int'(bus.wr_en), 4);
        chk("lit_aabb_sel2", int'(bus.wr_sel), 1);
        drive(0, 1, 0);
        chk("lit_aabb_wr_en3", int'(bus.wr_en), 8);
        chk("lit_aabb_sel3", int'(bus.wr_sel), 1);

        // push and pop while full: pop only
        drive(1, 1, 1);
        chk("lit_full_flag", int'(bus.fifo_full), 1);
        chk("lit_full_tail", int'(bus.curr_tail), 0);
        chk("lit_full_gnt", int'({bus.gnt_a, bus.gnt_b}), 0);
        chk("lit_full_pop", int'(bus.pop_ok), 1);
        drive(0, 0, 1);
        chk("lit_full_pop_count", int'(bus.count), 3);
        drive(1, 0, 0);
        drive(0, 0, 0);
        chk("lit_mid_count", int'(bus.count), 3);
        chk("lit_mid_head", int'(bus.curr_head), 2);
        chk("lit_mid_tail", int'(bus.curr_tail), 1);

        // asynchronous reset mid-stream, checked before any clock edge
        #1 rst = 1'b0;
        #1;
        chk("lit_async_count", int'(bus.count), 0);
        chk("lit_async_head", int'(bus.curr_head), 0);
        chk("lit_async_tail", int'(bus.curr_tail), 0);
        chk("lit_async_empty", int'(bus.fifo_empty), 1);
        @(posedge clk);
        #1 rst = 1'b1;

        // both requesting continuously: B, A, B, A, then blocked while full
        drive(1, 1, 0);
        chk("lit_rr0_b", int'(bus.gnt_b), 1);
        drive(1, 1, 0);
        chk("lit_rr1_a", int'(bus.gnt_a), 1);
        drive(1, 1, 0);
        chk("lit_rr2_b", int'(bus.gnt_b), 1);
        drive(1, 1, 0);
        chk("lit_rr3_a", int'(bus.gnt_a), 1);
        drive(1, 1, 0);
        chk("lit_rr_full_gnt", int'({bus.gnt_a, bus.gnt_b}), 0);
        drive(1, 1, 1);
        chk("lit_rr_full_pop_gnt", int'({bus.gnt_a, bus.gnt_b}), 0);
        drive(1, 1, 0);
        chk("lit_rr_after_pop_b", int'(bus.gnt_b), 1);
        chk("lit_rr_after_pop_count", int'(bus.count), 3);

        // push and pop together at count 2
        drive(0, 0, 1);
        drive(0, 0, 1);
        drive(1, 0, 1);
        chk("lit_pp2_count", int'(bus.count), 2);
        chk("lit_pp2_head", int'(bus.curr_head), 3);
        chk("lit_pp2_tail", int'(bus.curr_tail), 1);
        drive(0, 0, 0);
        chk("lit_pp2_count_after", int'(bus.count), 2);
        chk("lit_pp2_head_after", int'(bus.curr_head), 0);
        chk("lit_pp2_tail_after", int'(bus.curr_tail), 2);

        // drain, then push and pop together at empty
        drive(0, 0, 1);
        drive(0, 0, 1);
        drive(1, 0, 1);
        chk("lit_pe_empty", int'(bus.fifo_empty), 1);
        chk("lit_pe_pop_ok", int'(bus.pop_ok), 0);
        chk("lit_pe_gnt_a", int'(bus.gnt_a), 1);
        drive(0, 0, 0);
        chk("lit_pe_count", int'(bus.count), 1);
        drive(0, 0, 1);
        drive(0, 0, 1);
        chk("lit_idle_pop_ok", int'(bus.pop_ok), 0);
        drive(0, 0, 0);
        chk("lit_idle_count", int'(bus.count), 0);
        chk("lit_idle_head", int'(bus.curr_head), 3);
        chk("lit_idle_tail", int'(bus.curr_tail), 3);

        // wrap-around: six pushes interleaved with six pops
        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 0);
            drive(0, 0, 1);
        end
        drive(0, 0, 0);
        chk("lit_wrap_head", int'(bus.curr_head), 2);
        chk("lit_wrap_tail", int'(bus.curr_tail), 2);
        chk("lit_wrap_count", int'(bus.count), 0);
        chk("lit_wrap_empty", int'(bus.fifo_empty), 1);

        // randomized traffic, pop bias alternates so both full and empty are visited
        for (int i = 0; i < 3000; i++) begin
            int pop_pct;
            pop_pct = ((i / 100) % 2 == 0) ? 20 : 80;
            drive(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 99) < pop_pct));
            if ($urandom_range(0, 299) == 0)
                pulse_reset();
        end

        drive(0, 0, 0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
